lcs_array_ctrl: RTL and testbench

Sequencer for the systolic string-compare PE array. It buffers two character strings from a host stream: string A holds the row characters and string B holds the column characters. It then drives the array's row-load port and column-stream port with correctly framed valid strobes, counts result beats from the array's last PE, and returns the final score over a valid/ready handshake. It sits between the host interface and the edge inputs of the PE array. It replaces hand-driven testbench stimulus.

---
 rtl/lcs_array_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lcs_array_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcs_array_ctrl.sv
// Sequencer for the systolic string-compare PE array: buffers strings A/B from the host,
// frames the row-load and column-stream strobes, counts result beats and returns the score.
module lcs_array_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DRAIN_MAX = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] row_data,
  output logic              row_valid,
  output logic [DATA_W-1:0] col_data,
  output logic              col_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic [DATA_W-1:0] score,
  output logic              score_valid,
  input  logic              score_ready,
  output logic              err
);
  localparam int AW   = $clog2(ROWS + 1);
  localparam int BW   = $clog2(COLS + 1);
  localparam int KMAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int DW   = $clog2(DRAIN_MAX + 1);
  localparam int AIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BIW  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ROWLD, STREAM, DRAIN, DONE} state_t;

  state_t                      state_q;
  logic [ROWS-1:0][DATA_W-1:0] a_buf;
  logic [COLS-1:0][DATA_W-1:0] b_buf;
  logic [AW-1:0]               a_cnt_q;
  logic [BW-1:0]               b_cnt_q;
  logic [KW-1:0]               k_q;
  logic [BW-1:0]               beat_q;
  logic [DW-1:0]               dcnt_q;
  logic [DATA_W-1:0]           res_q;
  logic                        in_ready_q, busy_q, row_valid_q, col_valid_q, score_valid_q, err_q;
  logic [DATA_W-1:0]           row_data_q, col_data_q, score_q;

  logic           accept, a_wr, b_wr, beat, full;
  logic [AIW-1:0] ridx;
  logic [BIW-1:0] cidx;

  assign accept = in_valid & in_ready_q;
  assign a_wr   = accept & ~in_sel & (a_cnt_q != AW'(ROWS));
  assign b_wr   = accept &  in_sel & (b_cnt_q != BW'(COLS));
  assign full   = (a_cnt_q == AW'(ROWS)) & (b_cnt_q == BW'(COLS));
  assign beat   = res_valid & ((state_q == STREAM) | (state_q == DRAIN)) & (beat_q != BW'(COLS));
  // Rows go out last-first so that after shifting row r holds A[r].
  assign ridx   = AIW'(ROWS - 1 - int'(k_q));
  assign cidx   = BIW'(k_q);

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (a_wr) a_buf[a_cnt_q[AIW-1:0]] <= in_data;
    if (b_wr) b_buf[b_cnt_q[BIW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      a_cnt_q       <= '0;
      b_cnt_q       <= '0;
      k_q           <= '0;
      beat_q        <= '0;
      dcnt_q        <= '0;
      res_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      row_valid_q   <= 1'b0;
      row_data_q    <= '0;
      col_valid_q   <= 1'b0;
      col_data_q    <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (a_wr) a_cnt_q <= a_cnt_q + 1'b1;
      if (b_wr) b_cnt_q <= b_cnt_q + 1'b1;
      // Final beat value is held one cycle and published from DRAIN.
      if (beat) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == BW'(COLS - 1)) res_q <= res_data;
      end
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) state_q <= LOAD;
        end
        LOAD: begin
          if (start && full) begin
            state_q     <= ROWLD;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            row_valid_q <= 1'b1;
            row_data_q  <= a_buf[ROWS-1];
            k_q         <= KW'(1);
          end
        end
        ROWLD: begin
          if (k_q != KW'(ROWS)) begin
            row_data_q <= a_buf[ridx];
            k_q        <= k_q + 1'b1;
          end else begin
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            col_valid_q <= 1'b1;
            col_data_q  <= b_buf[0];
            k_q         <= KW'(1);
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (k_q != KW'(COLS)) begin
            col_data_q <= b_buf[cidx];
            k_q        <= k_q + 1'b1;
          end else begin
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            dcnt_q      <= '0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat_q == BW'(COLS)) begin
            score_q       <= res_q;
            err_q         <= 1'b0;
            score_valid_q <= 1'b1;
            state_q       <= DONE;
          end else if (dcnt_q == DW'(DRAIN_MAX)) begin
            score_q       <= '0;
            err_q         <= 1'b1;
            score_valid_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE: begin
          if (score_ready) begin
            score_valid_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            a_cnt_q       <= '0;
            b_cnt_q       <= '0;
            beat_q        <= '0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign row_data    = row_data_q;
  assign row_valid   = row_valid_q;
  assign col_data    = col_data_q;
  assign col_valid   = col_valid_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign err         = err_q;
endmodule

// File: tb/tb_lcs_array_ctrl.sv
// Bench for lcs_array_ctrl: vector table of strings/beats/expected score, a strobe
// scoreboard for row/column data, and hand sequences for reset, early start and overflow.
module tb_lcs_array_ctrl;
  localparam int DATA_W = 8, ROWS = 4, COLS = 4, DRAIN_MAX = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sel = 1'b0, start = 1'b0, res_valid = 1'b0, score_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0, res_data = '0;
  logic in_ready, busy, row_valid, col_valid, score_valid, err;
  logic [DATA_W-1:0] row_data, col_data, score;

  lcs_array_ctrl #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .start(start), .busy(busy), .row_data(row_data), .row_valid(row_valid),
    .col_data(col_data), .col_valid(col_valid), .res_data(res_data), .res_valid(res_valid),
    .score(score), .score_valid(score_valid), .score_ready(score_ready), .err(err));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] a, b, beats;
    int              nb;
    logic [7:0]      sc;
    logic            er;
    int              hold;
  } vec_t;

  int nerr = 0, nchk = 0;
  logic [7:0] rowq[$], colq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][7:0] mk(input string s);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = s[i];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic sel, input logic [7:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Strobe scoreboard: every row/column strobe pops the next expected character.
  always @(negedge clk) begin
    if (!rst) begin
      if (row_valid) begin
        if (rowq.size() == 0) chk("row_unexpected", 32'(row_data), 32'hFFFF);
        else chk("row_data", 32'(row_data), 32'(rowq.pop_front()));
      end else if (row_data != 0) chk("row_data_idle", 32'(row_data), 0);
      if (col_valid) begin
        if (colq.size() == 0) chk("col_unexpected", 32'(col_data), 32'hFFFF);
        else chk("col_data", 32'(col_data), 32'(colq.pop_front()));
      end else if (col_data != 0) chk("col_data_idle", 32'(col_data), 0);
    end
  end

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, v.a[i]);
      send(1'b1, v.b[i]);
    end
  endtask

  task automatic go(input vec_t v);
    int cyc;
    for (int i = ROWS - 1; i >= 0; i--) rowq.push_back(v.a[i]);
    for (int i = 0; i < COLS; i++) colq.push_back(v.b[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
    chk("in_ready_run", 32'(in_ready), 0);
    for (int k = 0; k < ROWS; k++) begin
      chk("row_frame", 32'(row_valid), 1);
      tick();
    end
    for (int k = 0; k < COLS; k++) begin
      chk("col_frame", 32'({row_valid, col_valid}), 1);
      tick();
    end
    chk("col_end", 32'(col_valid), 0);
    cyc = 0;
    for (int j = 0; j < v.nb; j++) begin
      res_valid = 1'b1; res_data = v.beats[j];
      tick(); cyc++;
      res_valid = 1'b0; res_data = '0;
      if (j < v.nb - 1) begin tick(); cyc++; end
    end
    while (!score_valid && cyc < 200) begin tick(); cyc++; end
    chk("score_latency", 32'(cyc), v.er ? 32'(DRAIN_MAX + 1) : 32'(2 * v.nb));
    chk("score", 32'(score), 32'(v.sc));
    chk("err", 32'(err), 32'(v.er));
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_valid_ready", 32'({score_valid, in_ready}), 32'b10);
      tick();
    end
    score_ready = 1'b1;
    tick();
    score_ready = 1'b0;
    chk("after_hs", 32'({score_valid, err, busy, in_ready}), 32'b0001);
    chk("score_held", 32'(score), 32'(v.sc));
    chk("queues_drained", 32'(rowq.size() + colq.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    vec_t v;
    int n;
    tbl[0] = '{mk("ABCD"), mk("ABCD"), {8'd4, 8'd3, 8'd2, 8'd1}, 4, 8'd4, 1'b0, 0};
    tbl[1] = '{mk("WXYZ"), mk("pqrs"), {8'd5, 8'd7, 8'd8, 8'd9}, 4, 8'd5, 1'b0, 10};
    tbl[2] = '{mk("LMNO"), mk("QRST"), {8'd0, 8'd3, 8'd2, 8'd1}, 3, 8'd0, 1'b1, 2};
    tbl[3] = '{mk("0123"), mk("4567"), {8'hA5, 8'd2, 8'd1, 8'd3}, 4, 8'hA5, 1'b0, 1};

    // Reset state
    repeat (3) tick();
    chk("reset_outs", 32'({in_ready, busy, row_valid, col_valid, score_valid, err}), 0);
    chk("reset_data", 32'({row_data, col_data, score}), 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    for (int t = 0; t < 4; t++) begin
      load(tbl[t]);
      go(tbl[t]);
    end

    // Early start with 3 A characters, then overflow of A
    send(1'b0, "E"); send(1'b0, "F"); send(1'b0, "G");
    for (int i = 0; i < 4; i++) send(1'b1, 8'("a" + i));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("early_start_busy", 32'({busy, row_valid}), 0);
    tick();
    chk("early_start_busy2", 32'(busy), 0);
    send(1'b0, "H"); send(1'b0, "Z");
    v = '{mk("EFGH"), mk("abcd"), {8'd8, 8'd6, 8'd4, 8'd2}, 4, 8'd8, 1'b0, 0};
    go(v);

    // Asynchronous reset in the middle of STREAM
    load(tbl[0]);
    for (int i = ROWS - 1; i >= 0; i--) rowq.push_back(tbl[0].a[i]);
    for (int i = 0; i < COLS; i++) colq.push_back(tbl[0].b[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!col_valid && n < 20) begin tick(); n++; end
    tick();
    chk("mid_stream_col_valid", 32'(col_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'({col_valid, busy, score_valid, row_valid, in_ready}), 0);
    chk("async_rst_data", 32'(col_data), 0);
    rowq.delete(); colq.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("in_ready_after_mid_rst", 32'({in_ready, busy}), 32'b10);
    load(tbl[3]);
    go(tbl[3]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
